digit_scan_ctrl: RTL and testbench



---
 rtl/scan_pkg.sv | 33 +++
 rtl/scan_tick.sv | 31 +++
 rtl/digit_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared types and helpers for the multiplexed digit scanner.
// Holds the scan state encoding, the largest legal BCD code and the
// leading-zero mask helper used when SCAN_LZB_EN is defined.
package scan_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_e;

    localparam logic [3:0] MAX_BCD    = 4'd9;
    localparam int         MAX_DIGITS = 8;

    // Bit i set means digit i is a leading zero and should stay dark.
    // Digit 0 is never blanked so an all-zero word still shows one "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] word,
        input int                      num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  seen;
        mask = '0;
        seen = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < num_digits) begin
                if (word[4*i +: 4] != 4'd0) seen = 1'b1;
                mask[i] = ~seen;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// scan_tick: dwell counter for one digit slot. Counts 0..DWELL_CYCLES-1
// while enabled and pulses tc on the terminal count; clears when idle.
module scan_tick #(
    parameter int DWELL_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    assign tc = en && (cnt_q == CNT_W'(DWELL_CYCLES - 1));

    // Dwell counter: wraps to zero on terminal count, held at zero while idle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || tc) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexes one registered BCD-to-7-segment decoder
// across NUM_DIGITS common-anode digits. A word offered on the load
// handshake waits in a pending register and moves to the shadow register
// only at the frame boundary, so a frame is never torn. Each digit is shown
// for DWELL_CYCLES clocks followed by one blank clock; the active-low anode
// enables are registered one clock behind dec to line up with the decoder.
// Optional feature: define SCAN_LZB_EN for leading-zero blanking.
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [3:0]              dec,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    bcd_err
);

    localparam int               IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_e                 state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [2:0]                  idx_ext;
    logic [NUM_DIGITS-1:0][3:0]  shadow_q, pend_q;
    logic [MAX_DIGITS-1:0]       blank_q;
    logic [NUM_DIGITS-1:0]       en_n_d;
    logic [3:0]                  cur_digit;
    logic                        tick_tc;
    logic                        frame_end;
    logic                        accept;
    logic                        in_bad;

    assign idx_ext   = 3'(idx_q);
    assign cur_digit = shadow_q[idx_q];
    assign dec       = cur_digit;
    assign accept    = load_valid && load_ready;
    // Last GAP cycle of the frame: the next edge starts digit 0 again.
    assign frame_end = (state_q == GAP) && (idx_q == LAST_IDX);

    scan_tick #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == SHOW),
        .tc    (tick_tc)
    );

    // Flag any non-BCD nibble in the offered word.
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > MAX_BCD) in_bad = 1'b1;
        end
    end

    // Handshake: capture into pending, promote to shadow at frame boundary.
    // A transfer on the boundary edge itself needs load_ready=1, which means
    // nothing was pending, so it lands in pending and waits a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ready <= 1'b1;
            pend_q     <= '0;
            shadow_q   <= '0;
            bcd_err    <= 1'b0;
        end else if (frame_end && !load_ready) begin
            shadow_q   <= pend_q;
            load_ready <= 1'b1;
        end else if (accept) begin
            pend_q     <= bcd_in;
            load_ready <= 1'b0;
            if (in_bad) bcd_err <= 1'b1;
        end
    end

`ifdef SCAN_LZB_EN
    localparam logic [MAX_DIGITS-1:0] RST_MASK = lz_mask('0, NUM_DIGITS);

    logic [4*MAX_DIGITS-1:0] pend_wide;
    logic [MAX_DIGITS-1:0]   pend_mask;

    // Leading-zero mask of the pending word, ready for the shadow load.
    always_comb begin
        pend_wide                   = '0;
        pend_wide[4*NUM_DIGITS-1:0] = pend_q;
        pend_mask                   = lz_mask(pend_wide, NUM_DIGITS);
    end

    // Blank mask tracks the shadow register; it changes only when it loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= RST_MASK;
        end else if (frame_end && !load_ready) begin
            blank_q <= pend_mask;
        end
    end
`else
    assign blank_q = '0;
`endif

    // Scan state, digit index and delayed anode enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SHOW;
            idx_q      <= '0;
            digit_en_n <= '1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            digit_en_n <= en_n_d;
        end
    end

    // Next state/index, plus the undelayed enable pattern for this cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        en_n_d  = '1;
        unique case (state_q)
            SHOW: begin
                if (tick_tc) state_d = GAP;
                if (cur_digit <= MAX_BCD && !blank_q[idx_ext]) en_n_d[idx_q] = 1'b0;
            end
            GAP: begin
                state_d = SHOW;
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
            default: state_d = SHOW;
        endcase
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: scoreboard bench for digit_scan_ctrl with
// NUM_DIGITS=4, DWELL_CYCLES=4 (frame = 20 clocks). The stimulus process
// issues loads at fixed edges and queues the hand-written slots it expects
// each frame to light; the monitor reassembles every lit slot from the
// pins and compares it with the head of the queue.
module tb_digit_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 4;

`ifdef SCAN_LZB_EN
    localparam logic [3:0] M_0000 = 4'b0001;
    localparam logic [3:0] M_0070 = 4'b0011;
`else
    localparam logic [3:0] M_0000 = 4'b1111;
    localparam logic [3:0] M_0070 = 4'b1111;
`endif
    localparam logic [3:0] M_1234 = 4'b1111;
    localparam logic [3:0] M_12A4 = 4'b1101;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [15:0]   bcd_in     = '0;
    logic [3:0]    dec;
    logic [ND-1:0] digit_en_n;
    logic          bcd_err;

    digit_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .bcd_in     (bcd_in),
        .dec        (dec),
        .digit_en_n (digit_en_n),
        .bcd_err    (bcd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    typedef struct {
        int         digit;
        logic [3:0] val;
    } slot_t;

    slot_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [15:0] w, input logic [3:0] m);
        for (int i = 0; i < ND; i++)
            if (m[i]) exp_q.push_back('{i, w[4*i +: 4]});
    endtask

    task automatic before_edge(input int n);
        while (cyc < n - 1) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] w, input int n);
        before_edge(n);
        check("ready_before_load", 32'(load_ready), 32'd1);
        bcd_in     = w;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        check("ready_after_load", 32'(load_ready), 32'd0);
    endtask

    // Monitor: a slot is a run of samples with the same single anode low.
    logic          run_active = 1'b0;
    logic [ND-1:0] run_en;
    logic [3:0]    run_dec;
    int            run_len;
    logic          run_bad;
    logic          prev_valid = 1'b0;
    logic [ND-1:0] prev_en;
    logic [3:0]    prev_dec;

    always @(negedge clk) begin
        if (!rst_n) begin
            run_active = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (run_active) begin
                if (digit_en_n != '1 && digit_en_n == run_en) begin
                    run_len++;
                    if (dec != run_dec) run_bad = 1'b1;
                end else begin
                    int dg;
                    slot_t e;
                    dg = -1;
                    for (int i = 0; i < ND; i++) if (!run_en[i]) dg = i;
                    run_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL slot_unexpected: digit %0d dec %h, none expected", dg, run_dec);
                    end else begin
                        e = exp_q.pop_front();
                        check("slot{digit,dec,len,bad}",
                              {8'(dg), run_dec, 8'(run_len), 4'(run_bad)},
                              {8'(e.digit), e.val, 8'(DW), 4'h0});
                    end
                end
            end
            if (!run_active && digit_en_n != '1) begin
                run_active = 1'b1;
                run_en     = digit_en_n;
                run_dec    = dec;
                run_len    = 1;
                // dec must already hold this value one clock before the anode drops
                run_bad    = !(prev_valid && prev_en == '1 && prev_dec == dec) ||
                             ($countones(~digit_en_n) != 1);
            end
            prev_en    = digit_en_n;
            prev_dec   = dec;
            prev_valid = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        push_frame(16'h0000, M_0000);   // frame 0
        push_frame(16'h0000, M_0000);   // frame 1
        push_frame(16'h1234, M_1234);   // frame 2
        push_frame(16'h0070, M_0070);   // frame 3
        push_frame(16'h12A4, M_12A4);   // frame 4
        push_frame(16'h1234, M_1234);   // frame 5
        push_frame(16'h1234, M_1234);   // frame 6: boundary load not yet visible
        push_frame(16'h5555, 4'b0011);  // frame 7: cut by reset during digit 2

        repeat (2) @(posedge clk);
        #1;
        check("rst_dec", 32'(dec), 32'h0);
        check("rst_en", 32'(digit_en_n), 32'hF);
        check("rst_ready", 32'(load_ready), 32'd1);
        check("rst_err", 32'(bcd_err), 32'd0);
        rst_n = 1'b1;

        do_load(16'h1234, 30);
        before_edge(40);
        check("ready_low_until_boundary", 32'(load_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_back_at_boundary", 32'(load_ready), 32'd1);
        check("err_clear_valid_words", 32'(bcd_err), 32'd0);

        do_load(16'h0070, 50);
        do_load(16'h12A4, 70);
        check("err_set_on_accept", 32'(bcd_err), 32'd1);
        do_load(16'h1234, 90);
        check("err_sticky", 32'(bcd_err), 32'd1);

        do_load(16'h5555, 120);         // accepted on the frame-boundary edge
        before_edge(130);
        check("ready_low_frame6_mid", 32'(load_ready), 32'd0);
        before_edge(140);
        check("ready_low_frame6_end", 32'(load_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_back_frame7", 32'(load_ready), 32'd1);

        do_load(16'h0070, 150);         // pending word that reset must discard
        before_edge(153);
        rst_n = 1'b0;
        #1;
        check("async_rst_en", 32'(digit_en_n), 32'hF);
        check("async_rst_dec", 32'(dec), 32'h0);
        check("async_rst_ready", 32'(load_ready), 32'd1);
        check("async_rst_err", 32'(bcd_err), 32'd0);
        push_frame(16'h0000, M_0000);   // frame 0 after reset
        push_frame(16'h0000, M_0000);   // frame 1 after reset
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("ready_after_reset", 32'(load_ready), 32'd1);

        before_edge(43);
        @(negedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
